// File: rtl/frogger_key_pkg.sv
// Shared keycode constants, hop FSM state type and direction-key decode.
// Latency: none (declarations and a combinational helper only).
// Backpressure: none; used by the hop command block and the frog mover.
package frogger_key_pkg;

  localparam logic [15:0] KEY_W    = 16'h001A;
  localparam logic [15:0] KEY_A    = 16'h0004;
  localparam logic [15:0] KEY_S    = 16'h0016;
  localparam logic [15:0] KEY_D    = 16'h0007;
  localparam logic [15:0] KEY_NONE = 16'h0000;

  // Width of the frame down-counter shared by hop, hold and repeat phases.
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOP,
    ST_HOLD,
    ST_REPEAT
  } hop_state_t;

  function automatic logic is_dir_key(input logic [15:0] k);
    return (k == KEY_W) || (k == KEY_A) || (k == KEY_S) || (k == KEY_D);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One-frame debounce of the raw keycode; stable_key is a direction code or NONE.
// Latency: a key must be seen on two consecutive edges (one frame of history).
// Backpressure: none; glitched or non-direction codes simply read as NONE.
module key_debounce
  import frogger_key_pkg::*;
(
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [15:0] raw_keycode,
  output logic [15:0] stable_key
);

  logic [15:0] raw_q;

  // Keep last frame's raw code so a changing input can be detected.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) raw_q <= KEY_NONE;
    else       raw_q <= raw_keycode;
  end

  // A key is only trusted when it matches last frame and is a movement key.
  always_comb begin
    stable_key = KEY_NONE;
    if ((raw_keycode == raw_q) && is_dir_key(raw_q)) stable_key = raw_q;
  end

endmodule

// File: rtl/frog_hop_cmd.sv
// Converts debounced key presses into bounded hop commands (optional auto-repeat via FROG_HOP_AUTOREPEAT_EN).
// Latency: hop driven after the second edge that sees the key; all outputs registered.
// Backpressure: none; enable low forces idle and aborts any hop in progress.
module frog_hop_cmd
  import frogger_key_pkg::*;
#(
  parameter int HOLD_FRAMES   = 20,
  parameter int REPEAT_FRAMES = 8,
  parameter int HOP_FRAMES    = 1
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [15:0] raw_keycode,
  input  logic        enable,
  output logic [15:0] keycode,
  output logic        hop_pulse,
  output logic [7:0]  hop_count
);

  localparam logic [CNT_W-1:0] HOP_LOAD    = CNT_W'(HOP_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_FRAMES - 1);

  logic [15:0]      stable_key;
  hop_state_t       state;
  logic [15:0]      cur_key;
  logic [CNT_W-1:0] cnt;
  logic             is_rep;   // current hop was an auto-repeat, not a fresh press

  key_debounce u_debounce (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .raw_keycode (raw_keycode),
    .stable_key  (stable_key)
  );

  // Hop sequencer; keycode/hop_pulse are registered alongside the state.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      cur_key   <= KEY_NONE;
      cnt       <= '0;
      is_rep    <= 1'b0;
      keycode   <= KEY_NONE;
      hop_pulse <= 1'b0;
      hop_count <= 8'd0;
    end else begin
      hop_pulse <= 1'b0;
      if (!enable) begin
        // Abort silently; a key still held on re-enable is treated as a new press.
        state   <= ST_IDLE;
        cnt     <= '0;
        is_rep  <= 1'b0;
        keycode <= KEY_NONE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (stable_key != KEY_NONE) begin
              state     <= ST_HOP;
              cur_key   <= stable_key;
              cnt       <= HOP_LOAD;
              is_rep    <= 1'b0;
              keycode   <= stable_key;
              hop_pulse <= 1'b1;
              hop_count <= hop_count + 8'd1;
            end else begin
              keycode <= KEY_NONE;
            end
          end
          ST_HOP: begin
            // Key changes mid-hop are ignored until the hop completes.
            if (cnt != '0) begin
              cnt     <= cnt - 1'b1;
              keycode <= cur_key;
            end else if (stable_key == cur_key) begin
              state   <= is_rep ? ST_REPEAT : ST_HOLD;
              cnt     <= is_rep ? REPEAT_LOAD : HOLD_LOAD;
              keycode <= KEY_NONE;
            end else begin
              state   <= ST_IDLE;
              keycode <= KEY_NONE;
            end
          end
          default: begin
            // ST_HOLD / ST_REPEAT: idle gap after a hop, or press lockout without repeat.
            keycode <= KEY_NONE;
            if (stable_key == KEY_NONE) begin
              state <= ST_IDLE;
            end else if (stable_key != cur_key) begin
              state     <= ST_HOP;
              cur_key   <= stable_key;
              cnt       <= HOP_LOAD;
              is_rep    <= 1'b0;
              keycode   <= stable_key;
              hop_pulse <= 1'b1;
              hop_count <= hop_count + 8'd1;
            end
`ifdef FROG_HOP_AUTOREPEAT_EN
            else if (cnt == '0) begin
              state     <= ST_HOP;
              cnt       <= HOP_LOAD;
              is_rep    <= 1'b1;
              keycode   <= cur_key;
              hop_pulse <= 1'b1;
              hop_count <= hop_count + 8'd1;
            end else begin
              cnt <= cnt - 1'b1;
            end
`else
            else begin
              state <= state;
            end
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frog_hop_cmd.sv
// Self-checking bench for frog_hop_cmd: directed scenarios plus random key sessions.
// Reference model schedules hops by absolute frame number rather than by FSM state.
// Works for both builds (FROG_HOP_AUTOREPEAT_EN defined or not).
module tb_frog_hop_cmd;

  localparam int P_HOP    = 1;
  localparam int P_HOLD   = 20;
  localparam int P_REPEAT = 8;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [15:0] raw_keycode;
  logic        enable;
  logic [15:0] keycode;
  logic        hop_pulse;
  logic [7:0]  hop_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 frame_clk = ~frame_clk;

  frog_hop_cmd #(
    .HOLD_FRAMES   (P_HOLD),
    .REPEAT_FRAMES (P_REPEAT),
    .HOP_FRAMES    (P_HOP)
  ) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .raw_keycode (raw_keycode),
    .enable      (enable),
    .keycode     (keycode),
    .hop_pulse   (hop_pulse),
    .hop_count   (hop_count)
  );

  // ---------------- reference model ----------------
  int          n_edge;
  logic [15:0] m_prev;
  bit          m_active;   // a hop or its follow-up wait is in progress
  logic [15:0] m_key;
  int          m_hop_end;  // edge at which the current hop is judged finished
  int          m_next;     // edge at which the next auto-repeat hop is due
  bit          m_rep;
  logic [15:0] m_kc;
  logic        m_pulse;
  logic [7:0]  m_cnt;

  function automatic bit is_move(input logic [15:0] k);
    return (k == 16'h001A) || (k == 16'h0004) || (k == 16'h0016) || (k == 16'h0007);
  endfunction

  task automatic model_reset();
    m_prev = 16'h0; m_active = 0; m_key = 16'h0; m_hop_end = 0; m_next = 0;
    m_rep = 0; m_kc = 16'h0; m_pulse = 1'b0; m_cnt = 8'd0;
  endtask

  task automatic m_start(input logic [15:0] k, input bit rep);
    m_active = 1; m_key = k; m_rep = rep;
    m_hop_end = n_edge + P_HOP;
    m_kc = k; m_pulse = 1'b1; m_cnt = m_cnt + 8'd1;
  endtask

  task automatic model_edge();
    logic [15:0] sk;
    sk = ((raw_keycode == m_prev) && is_move(m_prev)) ? m_prev : 16'h0;
    m_prev = raw_keycode;
    m_kc = 16'h0; m_pulse = 1'b0;
    if (!enable) m_active = 0;
    else if (!m_active) begin
      if (sk != 16'h0) m_start(sk, 0);
    end else if (n_edge < m_hop_end) m_kc = m_key;
    else if (n_edge == m_hop_end) begin
      if (sk == m_key) m_next = n_edge + (m_rep ? P_REPEAT : P_HOLD);
      else m_active = 0;
    end else if (sk == 16'h0) m_active = 0;
    else if (sk != m_key) m_start(sk, 0);
`ifdef FROG_HOP_AUTOREPEAT_EN
    else if (n_edge == m_next) m_start(m_key, 1);
`endif
  endtask

  // ---------------- checking ----------------
  task automatic check_outputs();
    n_cmp++;
    assert (keycode === m_kc) else begin
      n_bad++; $error("FAIL keycode @edge %0d: got %h want %h", n_edge, keycode, m_kc);
    end
    n_cmp++;
    assert (hop_pulse === m_pulse) else begin
      n_bad++; $error("FAIL hop_pulse @edge %0d: got %b want %b", n_edge, hop_pulse, m_pulse);
    end
    n_cmp++;
    assert (hop_count === m_cnt) else begin
      n_bad++; $error("FAIL hop_count @edge %0d: got %0d want %0d", n_edge, hop_count, m_cnt);
    end
    n_cmp++;
    assert ((keycode === 16'h0) || is_move(keycode)) else begin
      n_bad++; $error("FAIL keycode_legal @edge %0d: got %h want a direction or 0000", n_edge, keycode);
    end
  endtask

  task automatic frame(input logic [15:0] raw, input logic en);
    @(negedge frame_clk);
    raw_keycode = raw;
    enable      = en;
    @(posedge frame_clk);
    n_edge++;
    model_edge();
    #1 check_outputs();
  endtask

  task automatic check_count(input string tag, input logic [7:0] want);
    n_cmp++;
    assert (hop_count === want) else begin
      n_bad++; $error("FAIL %s: hop_count got %0d want %0d", tag, hop_count, want);
    end
  endtask

  task automatic check_idle_now(input string tag);
    n_cmp++;
    assert (keycode === 16'h0 && hop_pulse === 1'b0 && hop_count === 8'd0) else begin
      n_bad++; $error("FAIL %s: got kc=%h pulse=%b cnt=%0d want 0000/0/0", tag, keycode, hop_pulse, hop_count);
    end
  endtask

  logic [7:0]  c0;
  logic [15:0] keys [7];
  int          exp_hops;

  initial begin
    keys[0] = 16'h001A; keys[1] = 16'h0004; keys[2] = 16'h0016; keys[3] = 16'h0007;
    keys[4] = 16'h0000; keys[5] = 16'h0029; keys[6] = 16'h0000;
`ifdef FROG_HOP_AUTOREPEAT_EN
    exp_hops = 4;
`else
    exp_hops = 1;
`endif
    n_edge = 0;
    model_reset();
    Reset = 1'b1; raw_keycode = 16'h0; enable = 1'b0;
    repeat (3) @(posedge frame_clk);
    #1 check_idle_now("reset_values");
    @(negedge frame_clk) Reset = 1'b0;

    // One-frame tap is never stable: no hop.
    frame(16'h001A, 1'b1);
    repeat (4) frame(16'h0000, 1'b1);
    check_count("single_frame_tap", 8'd0);

    // Held 3 frames: exactly one hop.
    repeat (3) frame(16'h001A, 1'b1);
    repeat (3) frame(16'h0000, 1'b1);
    check_count("three_frame_press", 8'd1);

    // Long hold of D: repeats only in the auto-repeat build.
    c0 = hop_count;
    repeat (41) frame(16'h0007, 1'b1);
    repeat (3) frame(16'h0000, 1'b1);
    check_count("long_hold_hops", c0 + 8'(exp_hops));

    // Non-direction code never hops.
    c0 = hop_count;
    repeat (10) frame(16'h0029, 1'b1);
    frame(16'h0000, 1'b1);
    check_count("non_dir_key", c0);

    // A held, switched to S during the post-hop wait.
    c0 = hop_count;
    repeat (7) frame(16'h0004, 1'b1);
    repeat (3) frame(16'h0016, 1'b1);
    check_count("key_switch", c0 + 8'd2);
    repeat (2) frame(16'h0000, 1'b1);

    // Asynchronous reset while S hop is on the output.
    frame(16'h0016, 1'b1);
    frame(16'h0016, 1'b1);
    n_cmp++;
    assert (keycode === 16'h0016) else begin
      n_bad++; $error("FAIL hop_before_reset: keycode got %h want 0016", keycode);
    end
    #1 Reset = 1'b1;
    #1 check_idle_now("async_reset_midhop");
    #1 Reset = 1'b0;
    model_reset();

    // Enable low with a key held: nothing issued; re-enable counts as a new press.
    repeat (6) frame(16'h001A, 1'b0);
    check_count("enable_low_held", 8'd0);
    repeat (3) frame(16'h001A, 1'b1);
    check_count("enable_rise_press", 8'd1);
    frame(16'h0007, 1'b1);
    frame(16'h0007, 1'b1);
    frame(16'h0007, 1'b0);
    repeat (2) frame(16'h0000, 1'b1);

    // Random key sessions with glitches and enable drops.
    for (int s = 0; s < 70; s++) begin
      logic [15:0] k;
      logic        en;
      int          len;
      k   = keys[$urandom_range(0, 6)];
      if (k == 16'h0 && $urandom_range(0, 1) == 1) k = 16'($urandom);
      len = $urandom_range(1, 45);
      en  = ($urandom_range(0, 9) != 0);
      for (int f = 0; f < len; f++) begin
        if ($urandom_range(0, 19) == 0) frame(16'($urandom), en);
        else frame(k, en);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frog_hop_cmd.md
# frog_hop_cmd

Turns the raw 16-bit keyboard keycode into the frame-synchronous movement keycode consumed by the frog position controller. Each accepted key press produces one bounded hop command followed by idle (0x0000), so a single press moves the frog by one step instead of latching motion. Optional auto-repeat issues further hops while a key is held. Sits between the keyboard driver output and the frog mover; runs entirely on frame_clk (~60 Hz).

## Interface
- HOLD_FRAMES, 20: idle frames after the first hop before the first auto-repeat hop.
- REPEAT_FRAMES, 8: idle frames between subsequent auto-repeat hops.
- HOP_FRAMES, 1: frames each hop code is driven on keycode (≥1).
- frame_clk  in  1  frame clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- raw_keycode  in  16  keycode from the keyboard driver, any value, may glitch.
- enable  in  1  game-running qualifier; low forces idle.
- keycode  out  16  movement command to the mover: 0x001A (W/up), 0x0004 (A/left), 0x0016 (S/down), 0x0007 (D/right), or 0x0000 (none); no other value is ever driven.
- hop_pulse  out  1  high for the first frame of every hop.
- hop_count  out  8  total hops issued, wraps 255→0.

## Operation
- Debounce: raw_q <= raw_keycode each frame; stable = (raw_keycode == raw_q); stable_key = raw_q when stable and raw_q is one of the four direction codes, else NONE.
- States: IDLE, HOP, HOLD, REPEAT.
- IDLE: keycode=0. stable_key≠NONE and enable → HOP, cur_key<=stable_key, frame counter<=HOP_FRAMES-1, hop_pulse=1, hop_count+1.
- HOP: keycode=cur_key. Counter decrements; at 0: if stable_key==cur_key → HOLD (counter<=HOLD_FRAMES-1) after first hop, REPEAT (counter<=REPEAT_FRAMES-1) after a repeat hop; otherwise → IDLE.
- HOLD/REPEAT: keycode=0. stable_key==NONE → IDLE. stable_key valid and ≠cur_key → HOP with new key immediately (counts as first hop). Counter reaching 0 with same key → HOP (repeat hop, pulse, count+1).
- A key change during HOP does not cut the hop short; it is evaluated at HOP end.
- A glitched (unstable) frame evaluates as NONE.
- enable low: synchronous forced transition to IDLE, keycode=0 from next edge, in-progress hop aborted, no pulse. On enable rise with key held, the held key counts as a new press.

## Timing
- All outputs registered. Reset values: keycode=0x0000, hop_pulse=0, hop_count=0, state IDLE, raw_q=0, counters 0.
- Press latency: key present before edge e1 (sampled into raw_q), still present at e2 → keycode/hop_pulse valid after e2.
- Repeat spacing: first hop frame F; repeats at F+HOP_FRAMES+HOLD_FRAMES, then every HOP_FRAMES+REPEAT_FRAMES.
- Reset mid-operation clears all outputs immediately (asynchronous).

## Configuration
- FROG_HOP_AUTOREPEAT_EN defined: HOLD/REPEAT behaviour as above.
- Undefined: HOLD/REPEAT hop generation removed; after a hop the block waits in a lockout (keycode=0) until stable_key==NONE or differs from cur_key; a different valid key starts a new hop; held key never repeats. HOLD_FRAMES/REPEAT_FRAMES ignored.

## Structure
- Package frogger_key_pkg: KEY_W/KEY_A/KEY_S/KEY_D/KEY_NONE constants (16-bit), hop_state_t enum, function is_dir_key(). Shared with the mover.
- Sub-module key_debounce: raw_q register plus stable/valid decode, outputs stable_key.

## Test plan
- Reset, enable=1, raw=0x001A for exactly one frame then 0 → keycode stays 0x0000, hop_count=0.
- raw=0x001A held 3 frames then released (auto-repeat on) → keycode=0x001A for one frame, hop_pulse once, hop_count=1, then 0x0000.
- raw=0x0007 stable frames F..F+39 (auto-repeat on, defaults) → hops at F, F+21, F+30, F+39; hop_count=4; undefined macro → one hop only.
- raw=0x0029 held 10 frames → keycode 0x0000 throughout, no pulse.
- raw=0x0004 held, switched to 0x0016 at F+5 (in HOLD) → hop 0x0016 issued after the debounce edge, hop_count=2.
- Reset asserted during HOP with keycode=0x0016 → keycode=0, hop_count=0 immediately; enable low with key held → keycode 0 from next edge, no pulses.
